// File: rtl/aes_pkg.sv
// Shared widths and types for the byte-serial AES datapath.
package aes_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W      = $clog2(WORD_BYTES);

    typedef logic [BYTE_W-1:0] aes_byte_t;
    typedef logic [WORD_W-1:0] aes_word_t;

endpackage : aes_pkg

// File: rtl/aes_b2w_cnt.sv
// aes_b2w_cnt: byte-position counter for the word assembler.
// Wraps after the last byte of a word (3 -> 0).
// Ports:
//   clk, rst   clock, async active-high reset
//   i_en       advance by one
//   i_clr      synchronous clear, higher priority than i_en
//   o_last_c   counter currently points at the last byte of the word
module aes_b2w_cnt
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_last_c
);

    logic [CNT_W-1:0] r_cnt;

    // Power-of-two word length lets the counter wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_last_c = (r_cnt == CNT_W'(WORD_BYTES - 1));

endmodule : aes_b2w_cnt

// File: rtl/aes_byte_to_word.sv
// aes_byte_to_word: collects four serial bytes into one 32-bit word.
// The first accepted byte lands in pdout[31:24], the fourth in pdout[7:0].
// Optional feature macro: AES_B2W_CLR_EN adds the synchronous clear input clr.
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               synchronous realign/flush (AES_B2W_CLR_EN only)
//   din/din_valid     serial byte in
//   din_ready         byte can be taken this cycle (combinational)
//   pdout/pdout_valid assembled word
//   pdout_ready       consumer takes the word this cycle
module aes_byte_to_word
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
`ifdef AES_B2W_CLR_EN
    input  logic      clr,
`endif
    input  aes_byte_t din,
    input  logic      din_valid,
    output logic      din_ready,
    output aes_word_t pdout,
    output logic      pdout_valid,
    input  logic      pdout_ready
);

    aes_word_t r_sreg;
    logic      r_valid;
    logic      w_clr;
    logic      w_accept;
    logic      w_handoff;
    logic      w_last;

`ifdef AES_B2W_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    // A pending word blocks new bytes unless it leaves on this same edge.
    assign din_ready = !w_clr && (!r_valid || pdout_ready);
    assign w_accept  = din_valid && din_ready;
    assign w_handoff = r_valid && pdout_ready;

    aes_b2w_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_accept),
        .i_clr    (w_clr),
        .o_last_c (w_last)
    );

    // Shift register: newest byte enters at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (w_accept) begin
            r_sreg <= {r_sreg[WORD_W-BYTE_W-1:0], din};
        end
    end

    // Word-valid flag: completion wins over a same-edge handoff; clear wins over both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_clr) begin
            r_valid <= 1'b0;
        end else if (w_accept && w_last) begin
            r_valid <= 1'b1;
        end else if (w_handoff) begin
            r_valid <= 1'b0;
        end
    end

    assign pdout       = r_sreg;
    assign pdout_valid = r_valid;

endmodule : aes_byte_to_word

// File: tb/tb_aes_byte_to_word.sv
// Randomized and directed bench for aes_byte_to_word against a byte-queue model.
module tb_aes_byte_to_word;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] pdout;
    logic        pdout_valid;
    logic        pdout_ready;
`ifdef AES_B2W_CLR_EN
    logic        clr;
`endif

    always #5 clk = ~clk;

    aes_byte_to_word dut (
        .clk         (clk),
        .rst         (rst),
`ifdef AES_B2W_CLR_EN
        .clr         (clr),
`endif
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .pdout       (pdout),
        .pdout_valid (pdout_valid),
        .pdout_ready (pdout_ready)
    );

    // Reference model: bytes of the word in progress, the pending word and
    // the last four accepted bytes (what the output bus shows).
    logic [7:0]  m_part[$];
    logic        m_valid;
    logic [31:0] m_word;
    logic [31:0] m_last4;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        m_valid = 1'b0;
        m_word  = 32'h0;
        m_last4 = 32'h0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model, wait for the next falling edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c = 1'b0);
        bit exp_ready;
        bit acc;
        din_valid   = v;
        din         = d;
        pdout_ready = r;
`ifdef AES_B2W_CLR_EN
        clr         = c;
`endif
        #1;
        exp_ready = !c && (!m_valid || r);
        check("din_ready", 32'(din_ready), 32'(exp_ready));
        check("pdout_valid", 32'(pdout_valid), 32'(m_valid));
        check("pdout", pdout, m_last4);
        if (m_valid) check("word", pdout, m_word);
        acc = v && exp_ready;
        if (c) begin
            m_part.delete();
            m_valid = 1'b0;
        end else begin
            if (acc) begin
                m_part.push_back(d);
                m_last4 = (m_last4 << 8) | 32'(d);
            end
            if (m_part.size() == 4) begin
                m_word  = {m_part[0], m_part[1], m_part[2], m_part[3]};
                m_valid = 1'b1;
                m_part.delete();
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_pdout", pdout, 32'h0);
        check("rst_valid", 32'(pdout_valid), 32'h0);
        check("rst_ready", 32'(din_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        din         = 8'h0;
        din_valid   = 1'b0;
        pdout_ready = 1'b0;
`ifdef AES_B2W_CLR_EN
        clr         = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset mid-word discards partial bytes.
        cyc(1, 8'hEE, 1);
        cyc(1, 8'hFF, 1);
        do_reset();
        cyc(1, 8'h11, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        cyc(1, 8'h44, 0);
        check("mid_reset_word", pdout, 32'h11223344);
        check("mid_reset_valid", 32'(pdout_valid), 32'h1);
        cyc(0, 8'h00, 1);

        // Streaming with consumer always ready.
        cyc(1, 8'hA1, 1);
        cyc(1, 8'hB2, 1);
        cyc(1, 8'hC3, 1);
        cyc(1, 8'hD4, 1);
        check("stream_word", pdout, 32'hA1B2C3D4);
        cyc(0, 8'h00, 1);
        check("stream_one_cycle", 32'(pdout_valid), 32'h0);

        // Backpressure: E5 waits until the release cycle.
        cyc(1, 8'hA1, 0);
        cyc(1, 8'hB2, 0);
        cyc(1, 8'hC3, 0);
        cyc(1, 8'hD4, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'hE5, 0);
            check("bp_hold", pdout, 32'hA1B2C3D4);
        end
        cyc(1, 8'hE5, 1);
        check("bp_e5_taken", pdout, 32'hB2C3D4E5);
        check("bp_released", 32'(pdout_valid), 32'h0);
        do_reset();

        // Back-to-back 00..07.
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(i), 1);
            if (i == 3) check("b2b_w0", pdout, 32'h00010203);
        end
        check("b2b_w1", pdout, 32'h04050607);
        cyc(0, 8'h00, 1);

        // Gapped input, one byte every third cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'h5A + 8'(i), 1);
            if (i < 3) check("gap_not_yet", 32'(pdout_valid), 32'h0);
            cyc(0, 8'h00, 1);
            cyc(0, 8'h00, 1);
        end
        cyc(1, 8'h5A, 1);
        cyc(1, 8'h5B, 1);
        cyc(1, 8'h5C, 1);
        cyc(1, 8'h5D, 1);
        check("gap_word", pdout, 32'h5A5B5C5D);
        cyc(0, 8'h00, 1);

`ifdef AES_B2W_CLR_EN
        // Clear realigns the word and drops a pending word.
        cyc(1, 8'h01, 1);
        cyc(1, 8'h02, 1);
        cyc(1, 8'h99, 1, 1);
        cyc(1, 8'h10, 1);
        cyc(1, 8'h20, 1);
        cyc(1, 8'h30, 1);
        cyc(1, 8'h40, 0);
        check("clr_word", pdout, 32'h10203040);
        cyc(0, 8'h00, 0, 1);
        check("clr_drop_valid", 32'(pdout_valid), 32'h0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit c;
            c = 1'b0;
`ifdef AES_B2W_CLR_EN
            c = ($urandom_range(0, 31) == 0);
`endif
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0), c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_aes_byte_to_word

// File: doc/aes_byte_to_word.md
# aes_byte_to_word

Serial-to-parallel word assembler for the low-area byte-serial AES datapath: collects four consecutive bytes and presents them as one 32-bit word. It is the receive-side counterpart of the parallel-load/serial-unload byte shifter. Byte order matches that shifter: the first byte accepted lands in the highest byte of the word. Sits between byte-wide stages (S-box, key byte stream) and word-wide consumers (MixColumns column input, key-schedule word register).

## Interface
- No parameters; widths come from the shared package (byte = 8, word = 4 bytes).
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  8  serial byte in.
- din_valid  input  1  din carries a byte this cycle.
- din_ready  output  1  block accepts a byte this cycle.
- pdout  output  32  assembled word; first accepted byte in [31:24], fourth in [7:0].
- pdout_valid  output  1  pdout holds a complete word.
- pdout_ready  input  1  consumer takes pdout this cycle.
- clr  input  1  present only with AES_B2W_CLR_EN (see Configuration).

## Operation
- Byte accept: din_valid && din_ready at a rising edge.
- Byte transfer: din_valid && din_ready at a rising edge; the word is handed off when pdout_valid && pdout_ready at a rising edge.
- State:
  - 2-bit byte counter cnt (0..3).
  - 32-bit shift register sreg.
  - pdout_valid flag.
- On each accept:
  - sreg <= {sreg[23:0], din}.
  - cnt <= cnt + 1, wrapping 3 -> 0.
- Accept with cnt == 3 completes a word:
  - pdout_valid <= 1.
  - pdout is driven directly from sreg, so it then equals {b0, b1, b2, b3}.
- Word handoff (pdout_valid && pdout_ready) clears pdout_valid unless the same edge completes another word.
- din_ready = !pdout_valid || pdout_ready (combinational). No byte is accepted while a completed word is unconsumed.
- Simultaneous handoff and accept: legal. The old word leaves and the new byte shifts in on the same edge, giving zero-bubble streaming at one byte per cycle.
- pdout is stable while pdout_valid = 1 and pdout_ready = 0.
- din_valid = 0: no state change except handoff.

## Timing
- Reset values: cnt = 0, sreg = 0, pdout = 32'h0, pdout_valid = 0, din_ready = 1.
- Latency:
  - pdout_valid rises on the edge that accepts the 4th byte.
  - The word is visible in the cycle after that edge.
- Throughput: one word per 4 cycles with continuous valid/ready.
- Backpressure: while pdout_valid = 1 and pdout_ready = 0, din_ready = 0 and cnt/sreg are held.
- Reset mid-word: partial bytes are discarded; the next accepted byte is b0.
- din_valid with din_ready = 0: byte not taken; the source must hold it.

## Configuration
- AES_B2W_CLR_EN defined:
  - Adds the synchronous clear input clr.
  - clr = 1 at an edge forces cnt <= 0 and pdout_valid <= 0. sreg is left as is.
  - A byte presented the same cycle is dropped; din_ready = 0 while clr = 1.
  - clr has priority over accept and handoff.
- AES_B2W_CLR_EN undefined: the port is absent; only rst restarts word alignment.

## Structure
- Shared package aes_pkg holds:
  - Constants BYTE_W = 8 and WORD_BYTES = 4.
  - Typedefs aes_byte_t (logic [7:0]) and aes_word_t (logic [31:0]).
- Natural sub-module: aes_b2w_cnt, a 2-bit wrap counter with enable and clear that outputs a last flag (cnt == 3).
- The shift register and handshake stay in the top module.

## Test plan
- Reset -> pdout = 0, pdout_valid = 0, din_ready = 1. Assert rst mid-word after 2 bytes, then send 11, 22, 33, 44 -> word 32'h11223344.
- Stream A1, B2, C3, D4 on consecutive cycles with pdout_ready = 1 -> pdout_valid for 1 cycle after the 4th edge, pdout = 32'hA1B2C3D4.
- Same stream with pdout_ready = 0 for 5 cycles -> pdout held at A1B2C3D4, din_ready = 0, and byte E5 offered meanwhile is not consumed until the release cycle.
- Eight back-to-back bytes 00..07 with pdout_ready = 1 -> words 32'h00010203 then 32'h04050607, no idle cycle on din_ready.
- Gapped din_valid (byte every 3rd cycle) 5A, 5B, 5C, 5D -> 32'h5A5B5C5D, pdout_valid only after the 4th accept.
- With AES_B2W_CLR_EN: send 01, 02, pulse clr, send 10, 20, 30, 40 -> 32'h10203040. Also assert clr while pdout_valid = 1 -> pdout_valid drops next edge.
